mult_accumulator: RTL

Downstream consumer of the registered multiplier stage: counts `N_TERMS` consecutive product-valid beats, sums the products into a dot-product result, and presents the result on a valid/ready output handshake. Accumulation of the next group continues while a finished result waits to be accepted. A sticky flag records any result lost to back-pressure. The block sits between the multiplier's `out`/`ack` pair and the testbench or next datapath stage.

---
 rtl/mult_accumulator.sv | 99 +++++++++
 1 files changed

// File: rtl/mult_accumulator.sv
// ============================================================================
// Module      : mult_accumulator
// Description : Sums N_TERMS consecutive valid products into a dot-product
//               result presented on a valid/ready output slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_accumulator #(
    parameter int PROD_W  = 16,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PROD_W-1:0]            prod,
    input  logic                         prod_vld,
    input  logic                         clr,
    output logic [ACC_W-1:0]             sum,
    output logic                         sum_vld,
    input  logic                         sum_rdy,
    output logic [$clog2(N_TERMS):0]     term_cnt,
    output logic                         ovf
);

    localparam int CNT_W = $clog2(N_TERMS) + 1;

    generate
        if (ACC_W < PROD_W + $clog2(N_TERMS)) begin : g_bad_acc_width
            $error("mult_accumulator: ACC_W too narrow for N_TERMS products of PROD_W bits");
        end
        if (N_TERMS < 1) begin : g_bad_n_terms
            $error("mult_accumulator: N_TERMS must be at least 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t            state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] done_val;
    logic             last;

    assign done_val = acc + ACC_W'(prod);
    assign last     = prod_vld && (term_cnt == CNT_W'(N_TERMS - 1));
    assign sum_vld  = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            term_cnt <= '0;
            sum      <= '0;
            state    <= EMPTY;
            ovf      <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            term_cnt <= '0;
            state    <= EMPTY;
            ovf      <= 1'b0;
        end else begin
            if (last) begin
                acc      <= '0;
                term_cnt <= '0;
            end else if (prod_vld) begin
                acc      <= done_val;
                term_cnt <= term_cnt + CNT_W'(1);
            end

            // The slot never stalls accumulation; a completion into an
            // unaccepted slot is dropped and remembered in ovf.
            case (state)
                EMPTY: begin
                    if (last) begin
                        state <= FULL;
                        sum   <= done_val;
                    end
                end
                FULL: begin
                    if (last) begin
                        if (sum_rdy) begin
                            sum <= done_val;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (sum_rdy) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

`default_nettype wire
